// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, CC layout and FSM state type shared by the ALU block
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SHL = 4'd5;
    localparam logic [3:0] ALU_SHR = 4'd6;
    localparam logic [3:0] ALU_SAR = 4'd7;
    localparam logic [3:0] ALU_MUL = 4'd8;

    localparam int CC_ZF = 2;
    localparam int CC_SF = 1;
    localparam int CC_OF = 0;

    localparam logic [2:0] CC_RST = 3'b100;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// rtl/alu_mul_iter.sv - iterative shift-add unsigned multiplier, one partial product per cycle
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               done_o,
    output logic [2*WIDTH-1:0] prod_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [CW-1:0]      count_q;

    // prod_o carries the accumulator value being written this edge, so the
    // caller can capture the final product on the same edge that count hits 0.
    always_comb begin
        acc_d  = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod_o = acc_d;
        done_o = (count_q == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            count_q  <= '0;
        end else if (start_i) begin
            mcand_q  <= {{WIDTH{1'b0}}, a_i};
            mplier_q <= b_i;
            acc_q    <= '0;
            count_q  <= CW'(WIDTH);
        end else if (count_q != '0) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked execute-stage ALU with registered result, CC register and iterative MUL
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] aluA,
    input  logic [WIDTH-1:0] aluB,
    input  logic [3:0]       alufun,
    input  logic             set_cc,
    output logic             out_valid,
    output logic [WIDTH-1:0] valE,
    output logic [2:0]       cc,
    output logic             err
);

    alu_state_e         state_q, state_d;
    logic [WIDTH-1:0]   vale_q, vale_d;
    logic [2:0]         cc_q, cc_d;
    logic               err_q, err_d;
    logic               ov_q, ov_d;
    logic               setcc_q, setcc_d;

    logic [WIDTH-1:0]   res;
    logic               res_of;
    logic               legal;
    logic [SHW-1:0]     sh;
    logic               accept;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] prod;

    assign in_ready  = (state_q == S_IDLE);
    assign accept    = in_valid && in_ready;
    assign sh        = aluB[SHW-1:0];
    assign out_valid = ov_q;
    assign valE      = vale_q;
    assign cc        = cc_q;
    assign err       = err_q;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start_i (mul_start),
        .a_i     (aluA),
        .b_i     (aluB),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    // Single-cycle datapath; MUL is handled by the iterative unit.
    always_comb begin
        res    = '0;
        res_of = 1'b0;
        legal  = 1'b1;
        case (alufun)
            ALU_ADD: begin
                res    = aluA + aluB;
                res_of = (aluA[WIDTH-1] == aluB[WIDTH-1]) && (res[WIDTH-1] != aluA[WIDTH-1]);
            end
            ALU_SUB: begin
                res    = aluA - aluB;
                res_of = (aluA[WIDTH-1] != aluB[WIDTH-1]) && (res[WIDTH-1] != aluA[WIDTH-1]);
            end
            ALU_AND: res = aluA & aluB;
            ALU_XOR: res = aluA ^ aluB;
            ALU_OR:  res = aluA | aluB;
            ALU_SHL: res = aluA << sh;
            ALU_SHR: res = aluA >> sh;
            ALU_SAR: res = $signed(aluA) >>> sh;
            ALU_MUL: res = '0;
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        vale_d    = vale_q;
        cc_d      = cc_q;
        err_d     = err_q;
        ov_d      = 1'b0;
        setcc_d   = setcc_q;
        mul_start = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (alufun == ALU_MUL) begin
                        mul_start = 1'b1;
                        setcc_d   = set_cc;
                        state_d   = S_BUSY;
                    end else begin
                        ov_d   = 1'b1;
                        vale_d = legal ? res : '0;
                        err_d  = !legal;
                        if (legal && set_cc) begin
                            cc_d[CC_ZF] = (res == '0);
                            cc_d[CC_SF] = res[WIDTH-1];
                            cc_d[CC_OF] = res_of;
                        end
                    end
                end
            end
            S_BUSY: begin
                if (mul_done) begin
                    state_d = S_IDLE;
                    ov_d    = 1'b1;
                    vale_d  = prod[WIDTH-1:0];
                    err_d   = 1'b0;
                    if (setcc_q) begin
                        cc_d[CC_ZF] = (prod[WIDTH-1:0] == '0);
                        cc_d[CC_SF] = prod[WIDTH-1];
                        cc_d[CC_OF] = |prod[2*WIDTH-1:WIDTH];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            vale_q  <= '0;
            cc_q    <= CC_RST;
            err_q   <= 1'b0;
            ov_q    <= 1'b0;
            setcc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vale_q  <= vale_d;
            cc_q    <= cc_d;
            err_q   <= err_d;
            ov_q    <= ov_d;
            setcc_q <= setcc_d;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq at WIDTH=32
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  aluA, aluB;
    logic [3:0]    alufun;
    logic          set_cc;
    logic          out_valid;
    logic [W-1:0]  valE;
    logic [2:0]    cc;
    logic          err;

    int n_vec = 0;
    int n_err = 0;
    logic [2:0] model_cc;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .aluA      (aluA),
        .aluB      (aluB),
        .alufun    (alufun),
        .set_cc    (set_cc),
        .out_valid (out_valid),
        .valE      (valE),
        .cc        (cc),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sc;
        logic [31:0] ev;
        logic [2:0]  ecc;
        logic        eerr;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic on the architectural rules.
    task automatic ref_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                             input logic sc, input logic [2:0] cin,
                             output logic [31:0] r, output logic [2:0] cout, output logic e);
        logic [63:0] p;
        logic [4:0]  s;
        logic        of;
        s  = b[4:0];
        e  = 1'b0;
        of = 1'b0;
        r  = '0;
        case (op)
            4'd0: begin r = a + b; of = (a[31] == b[31]) && (r[31] != a[31]); end
            4'd1: begin r = a - b; of = (a[31] != b[31]) && (r[31] != a[31]); end
            4'd2: r = a & b;
            4'd3: r = a ^ b;
            4'd4: r = a | b;
            4'd5: r = a << s;
            4'd6: r = a >> s;
            4'd7: r = (a >> s) | (a[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
            4'd8: begin p = 64'(a) * 64'(b); r = p[31:0]; of = (p[63:32] != 0); end
            default: e = 1'b1;
        endcase
        cout = (!e && sc) ? {r == 0, r[31], of} : cin;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic [31:0] ev, input logic [2:0] ecc,
                         input logic eerr, input string name);
        int cyc;
        logic saw_ready;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " ready"}, in_ready, 1);
        alufun = op; aluA = a; aluB = b; set_cc = sc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (op == ALU_MUL) begin
            cyc = 0;
            saw_ready = 1'b0;
            while (!out_valid && cyc < 40) begin
                if (in_ready) saw_ready = 1'b1;
                @(posedge clk); #1;
                cyc++;
            end
            chk({name, " mul latency"}, cyc, W);
            chk({name, " busy ready"}, saw_ready, 0);
            chk({name, " ready on result"}, in_ready, 1);
        end
        chk({name, " out_valid"}, out_valid, 1);
        chk({name, " valE"}, valE, ev);
        chk({name, " err"}, err, eerr);
        chk({name, " cc"}, cc, ecc);
        model_cc = ecc;
        @(posedge clk); #1;
        chk({name, " pulse"}, out_valid, 0);
    endtask

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] r, a, b;
        logic [3:0]  op;
        logic [2:0]  c;
        logic        e, sc, saw;

        vecs[0]  = '{ALU_SUB, 32'hEECE2ADD, 32'h7EFFC55C, 1'b1, 32'h6FCE6581, 3'b001, 1'b0};
        vecs[1]  = '{ALU_ADD, 32'h1,        32'h1,        1'b0, 32'h2,        3'b001, 1'b0};
        vecs[2]  = '{ALU_MUL, 32'h7,        32'h6,        1'b1, 32'h2A,       3'b000, 1'b0};
        vecs[3]  = '{ALU_MUL, 32'h10000,    32'h10000,    1'b1, 32'h0,        3'b101, 1'b0};
        vecs[4]  = '{ALU_SAR, 32'h80000000, 32'd4,        1'b1, 32'hF8000000, 3'b010, 1'b0};
        vecs[5]  = '{ALU_SHR, 32'h80000000, 32'd36,       1'b1, 32'h08000000, 3'b000, 1'b0};
        vecs[6]  = '{ALU_SHL, 32'h12345678, 32'd0,        1'b1, 32'h12345678, 3'b000, 1'b0};
        vecs[7]  = '{4'hF,    32'h5,        32'h5,        1'b1, 32'h0,        3'b000, 1'b1};
        vecs[8]  = '{ALU_OR,  32'hF0,       32'h0F,       1'b0, 32'hFF,       3'b000, 1'b0};
        vecs[9]  = '{ALU_XOR, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0,        3'b100, 1'b0};
        vecs[10] = '{ALU_ADD, 32'hFFFFFFFF, 32'h1,        1'b1, 32'h0,        3'b100, 1'b0};
        vecs[11] = '{ALU_SUB, 32'h80000000, 32'h1,        1'b1, 32'h7FFFFFFF, 3'b001, 1'b0};
        vecs[12] = '{ALU_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h1,        3'b001, 1'b0};

        rst = 1'b1; in_valid = 1'b0; aluA = '0; aluB = '0; alufun = '0; set_cc = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset cc", cc, 3'b100);
        chk("reset valE", valE, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset err", err, 0);
        chk("reset in_ready", in_ready, 1);

        // back-to-back ADD then AND
        alufun = ALU_ADD; aluA = 32'h7FFED28A; aluB = 32'h7FFED28A; set_cc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b add out_valid", out_valid, 1);
        chk("b2b add valE", valE, 32'hFFFDA514);
        chk("b2b add cc", cc, 3'b011);
        alufun = ALU_AND; aluA = 32'h1100; aluB = 32'h11;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("b2b and out_valid", out_valid, 1);
        chk("b2b and valE", valE, 0);
        chk("b2b and cc", cc, 3'b100);
        @(posedge clk); #1;
        chk("b2b idle", out_valid, 0);
        model_cc = 3'b100;

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sc,
                  vecs[i].ev, vecs[i].ecc, vecs[i].eerr, $sformatf("vec%0d", i));

        // reset at the 10th multiply iteration aborts the op
        alufun = ALU_MUL; aluA = 32'd123; aluB = 32'd456; set_cc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort out_valid", out_valid, 0);
        chk("abort cc", cc, 3'b100);
        chk("abort in_ready", in_ready, 1);
        saw = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) saw = 1'b1;
            @(posedge clk); #1;
        end
        chk("abort no result", saw, 0);
        model_cc = 3'b100;
        do_op(ALU_ADD, 32'd1, 32'd2, 1'b1, 32'd3, 3'b000, 1'b0, "post-abort add");

        // reset wins over a simultaneous issue
        alufun = ALU_ADD; aluA = 32'd5; aluB = 32'd5; set_cc = 1'b1; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst drop out_valid", out_valid, 0);
        @(posedge clk); #1;
        chk("rst drop later", out_valid, 0);
        chk("rst drop cc", cc, 3'b100);
        model_cc = 3'b100;

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) a = b;
            sc = 1'($urandom);
            ref_model(op, a, b, sc, model_cc, r, c, e);
            do_op(op, a, b, sc, r, c, e, $sformatf("rnd%0d op%0d", i, op));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
